// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin fetch/data arbiter in front of the single UART-backed LSU
// Ports: clk/reset (sync, active-high); fetch side if_req/if_addr -> if_ready/if_rdata;
// data side d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata; LSU side lsu_en/lsu_addr/lsu_wdata
// -> lsu_rdata/lsu_done; status busy, gnt_fetch (owner of current/last op), sticky timeout.
module lsu_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ready,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    output logic [1:0]  lsu_en,
    output logic [7:0]  lsu_addr,
    output logic [15:0] lsu_wdata,
    input  logic [15:0] lsu_rdata,
    input  logic        lsu_done,
    output logic        busy,
    output logic        gnt_fetch,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    state_t state, state_nx;
    logic [CNT_W-1:0] wdog, wdog_nx;
    logic grant, pick_fetch;
    always_comb begin
        grant = if_req || d_req;
        // gnt_fetch doubles as last-grant: fetch wins unless data is alone or fetch went last
        pick_fetch = if_req && (!d_req || !gnt_fetch);
        wdog_nx = (wdog == '1) ? wdog : wdog + 1'b1;
        state_nx = (state == IDLE) ? (grant ? BUSY : IDLE) :
                   (state == BUSY) ? (lsu_done ? RESP : BUSY) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    assign busy = (state != IDLE);
    always_ff @(posedge clk) begin
        if (reset) begin
            lsu_en    <= 2'b00;
            lsu_addr  <= '0;
            lsu_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            gnt_fetch <= 1'b0;
            timeout   <= 1'b0;
            wdog      <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (state == IDLE && grant) begin
                gnt_fetch <= pick_fetch;
                lsu_en    <= (pick_fetch || !d_we) ? 2'b01 : 2'b10;
                lsu_addr  <= pick_fetch ? if_addr : d_addr;
                lsu_wdata <= pick_fetch ? 16'h0000 : d_wdata;
                wdog      <= '0;
            end
            if (state == BUSY) begin
                wdog <= wdog_nx;
                if (TIMEOUT_CYCLES != 0 && wdog_nx == TO_VAL)
                    timeout <= 1'b1;
                if (lsu_done) begin
                    // dropping en here keeps the LSU from restarting in its flag-send state
                    lsu_en   <= 2'b00;
                    if_ready <= gnt_fetch;
                    d_ready  <= !gnt_fetch;
                    if (lsu_en == 2'b01 && gnt_fetch)
                        if_rdata <= lsu_rdata;
                    if (lsu_en == 2'b01 && !gnt_fetch)
                        d_rdata <= lsu_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed scoreboard bench for lsu_arbiter
module tb_lsu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, lsu_done;
    logic [7:0]  if_addr, d_addr;
    logic [15:0] d_wdata, lsu_rdata;
    logic        if_ready, d_ready, busy, gnt_fetch, timeout;
    logic [15:0] if_rdata, d_rdata, lsu_wdata;
    logic [1:0]  lsu_en;
    logic [7:0]  lsu_addr;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        f;
        logic [15:0] rd;
    } exp_t;
    exp_t sb[$];

    lsu_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .lsu_en(lsu_en), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .busy(busy), .gnt_fetch(gnt_fetch), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic f, input logic [15:0] rd);
        exp_t e;
        e.f = f;
        e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic run_done(input logic [15:0] rd, input int waitc);
        cyc(waitc);
        lsu_rdata = rd;
        lsu_done = 1'b1;
        cyc(1);
        lsu_done = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int n = 0;
        while (!(if_ready || d_ready) && n < 10) begin
            cyc(1);
            n++;
        end
        chk("ready_seen", {31'b0, if_ready | d_ready}, 32'd1);
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("if_ready", {31'b0, if_ready}, {31'b0, e.f});
            chk("d_ready", {31'b0, d_ready}, {31'b0, !e.f});
            chk("rdata", e.f ? {16'b0, if_rdata} : {16'b0, d_rdata}, {16'b0, e.rd});
        end
        chk("en_resp", {30'b0, lsu_en}, 32'd0);
        chk("busy_resp", {31'b0, busy}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; lsu_done = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; lsu_rdata = 0;
        cyc(2);
        chk("rst_en", {30'b0, lsu_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        chk("rst_gnt", {31'b0, gnt_fetch}, 32'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        chk("rst_ready", {30'b0, if_ready, d_ready}, 32'd0);
        reset = 1'b0;
        cyc(1);

        // single fetch
        if_req = 1; if_addr = 8'h12;
        push(1'b1, 16'hBEEF);
        cyc(1);
        if_req = 0; if_addr = 8'hFF;
        chk("f_en", {30'b0, lsu_en}, 32'd1);
        chk("f_addr", {24'b0, lsu_addr}, 32'h12);
        chk("f_wdata", {16'b0, lsu_wdata}, 32'd0);
        chk("f_gnt", {31'b0, gnt_fetch}, 32'd1);
        run_done(16'hBEEF, 2);
        collect();
        cyc(1);
        chk("f_ready_drop", {30'b0, if_ready, d_ready}, 32'd0);
        chk("f_idle", {31'b0, busy}, 32'd0);

        // single store
        d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 16'hA55A;
        push(1'b0, 16'h0000);
        cyc(1);
        d_req = 0; d_we = 0; d_wdata = 16'h0;
        chk("s_en", {30'b0, lsu_en}, 32'd2);
        chk("s_addr", {24'b0, lsu_addr}, 32'h40);
        chk("s_wdata", {16'b0, lsu_wdata}, 32'hA55A);
        chk("s_gnt", {31'b0, gnt_fetch}, 32'd0);
        cyc(2);
        chk("s_en_hold", {30'b0, lsu_en}, 32'd2);
        chk("s_wdata_hold", {16'b0, lsu_wdata}, 32'hA55A);
        run_done(16'h1234, 0);
        collect();
        cyc(1);

        // done while idle is ignored
        lsu_rdata = 16'hFFFF; lsu_done = 1;
        cyc(1);
        lsu_done = 0;
        chk("idle_done_busy", {31'b0, busy}, 32'd0);
        chk("idle_done_en", {30'b0, lsu_en}, 32'd0);
        chk("idle_done_ready", {30'b0, if_ready, d_ready}, 32'd0);
        chk("idle_done_rdata", {if_rdata, d_rdata}, 32'hBEEF0000);

        // contention from reset: fetch, data, fetch, data
        reset = 1;
        cyc(1);
        reset = 0;
        if_req = 1; d_req = 1; d_we = 0; if_addr = 8'h21; d_addr = 8'h31;
        for (int k = 0; k < 4; k++) begin
            push(k % 2 == 0, 16'h1000 + 16'(k));
            cyc(1);
            chk("rr_gnt", {31'b0, gnt_fetch}, {31'b0, k % 2 == 0});
            chk("rr_addr", {24'b0, lsu_addr}, (k % 2 == 0) ? 32'h21 : 32'h31);
            chk("rr_en", {30'b0, lsu_en}, 32'd1);
            run_done(16'h1000 + 16'(k), 1);
            collect();
            cyc(1);
            chk("rr_gap_en", {30'b0, lsu_en}, 32'd0);
            chk("rr_gap_busy", {31'b0, busy}, 32'd0);
        end
        if_req = 0; d_req = 0;
        cyc(1);

        // watchdog
        if_req = 1; if_addr = 8'h55;
        cyc(1);
        if_req = 0;
        cyc(7);
        chk("wd_before", {31'b0, timeout}, 32'd0);
        cyc(1);
        chk("wd_set", {31'b0, timeout}, 32'd1);
        cyc(5);
        chk("wd_sticky", {31'b0, timeout}, 32'd1);
        chk("wd_still_busy", {30'b0, lsu_en}, 32'd1);
        push(1'b1, 16'hCAFE);
        run_done(16'hCAFE, 0);
        collect();
        cyc(2);
        chk("wd_after_done", {31'b0, timeout}, 32'd1);

        // reset in the middle of a transaction
        reset = 1;
        cyc(1);
        reset = 0;
        chk("wd_cleared", {31'b0, timeout}, 32'd0);
        if_req = 1; if_addr = 8'h66;
        cyc(1);
        if_req = 0;
        cyc(3);
        reset = 1;
        cyc(1);
        reset = 0;
        chk("ab_en", {30'b0, lsu_en}, 32'd0);
        chk("ab_busy", {31'b0, busy}, 32'd0);
        chk("ab_ready", {30'b0, if_ready, d_ready}, 32'd0);
        cyc(2);
        chk("ab_no_ready", {30'b0, if_ready, d_ready}, 32'd0);
        if_req = 1; if_addr = 8'h77;
        push(1'b1, 16'h7777);
        cyc(1);
        if_req = 0;
        chk("ab_new_en", {30'b0, lsu_en}, 32'd1);
        chk("ab_new_addr", {24'b0, lsu_addr}, 32'h77);
        run_done(16'h7777, 1);
        collect();
        cyc(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
Two-requester arbiter that shares the single UART-backed load/store unit between the instruction-fetch path and the data load/store path. It latches one request at a time and drives the LSU command bus (en/address/data_to_store). It waits for the LSU done pulse, then returns read data and a one-cycle ready pulse to the winning requester. Round-robin on contention; a watchdog flags transactions that never complete.

Parameters:
TIMEOUT_CYCLES, 4096, cycles in BUSY before sticky timeout flag sets; 0 disables watchdog
CNT_W, 16, watchdog counter width; counter saturates at all-ones

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, level; addr sampled at grant
if_addr  input  8  fetch address
if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  output  16  fetched instruction, held until next fetch completes
d_req  input  1  data request, level
d_we  input  1  1 = store, 0 = load; sampled at grant
d_addr  input  8  data address
d_wdata  input  16  store data, sampled at grant
d_ready  output  1  one-cycle pulse: data op complete
d_rdata  output  16  load result, updated only on loads, held otherwise
lsu_en  output  2  to LSU: 00 idle, 01 LOAD, 10 STORE; registered
lsu_addr  output  8  to LSU address, registered
lsu_wdata  output  16  to LSU data_to_store, registered
lsu_rdata  input  16  from LSU data_to_load
lsu_done  input  1  from LSU done (high one cycle)
busy  output  1  high in BUSY and RESP
gnt_fetch  output  1  owner of current/last transaction: 1 fetch, 0 data
timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, active-high) -> state IDLE; lsu_en=00, lsu_addr=0, lsu_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, busy=0, timeout=0, watchdog=0; last-grant = data, so fetch wins first contention.
- Reset mid-transaction: abort immediately, lsu_en=00 next cycle, no ready pulse; LSU recovery is via its own reset.
- States: IDLE, BUSY, RESP.
- IDLE: if only one req high -> grant it. If both high -> grant the requester not granted last. On the grant edge: latch addr (and we/wdata for data; fetch forces LOAD, lsu_wdata=0), set lsu_en (01 load, 10 store), update gnt_fetch/last-grant, clear watchdog, go BUSY. No req -> stay; lsu_en=00.
- Latency: req high at edge N -> lsu_en valid after edge N.
- BUSY: lsu_en/addr/wdata held constant. Watchdog increments each cycle, saturating. When it equals TIMEOUT_CYCLES (nonzero), timeout<=1; the transaction keeps waiting.
- BUSY + lsu_done=1 at edge M: lsu_en<=00, so the LSU sees en=00 in its flag-send state and does not restart. For a load, capture lsu_rdata into if_rdata or d_rdata of the owner. Assert the owner's ready for the cycle after M, go RESP.
- RESP: one cycle, ready high, then IDLE. Requester must have req low in the cycle after ready unless issuing a new request; a high req there is a new request.
- Back-to-back: minimum spacing between lsu_en assertions is 2 idle cycles (RESP, IDLE), so en=00 is seen for >=2 cycles.
- lsu_done in IDLE or RESP: ignored.
- if_ready and d_ready are never high together; ready is only asserted to the owner.
- Requests are not queued beyond the level req; requester inputs may change after the grant edge without effect.

Test Plan:
- Reset then if_req=1, if_addr=0x12; LSU model returns 0xBEEF -> lsu_en=01, lsu_addr=0x12 the cycle after req. After lsu_done: lsu_en=00, if_ready one cycle, if_rdata=0xBEEF, d_ready never high.
- d_req=1, d_we=1, d_addr=0x40, d_wdata=0xA55A -> lsu_en=10, lsu_addr=0x40, lsu_wdata=0xA55A held through BUSY. d_ready pulses after done; d_rdata unchanged (0).
- if_req and d_req both held high from reset, 4 transactions -> grant order fetch, data, fetch, data; gnt_fetch toggles accordingly.
- lsu_done pulsed while IDLE -> no state change, no ready, lsu_en stays 00.
- TIMEOUT_CYCLES=8, withhold lsu_done -> timeout rises on the 8th BUSY cycle and stays 1. A later lsu_done completes normally, and timeout stays 1 until reset.
- Reset asserted 3 cycles into BUSY -> next cycle lsu_en=00, busy=0, no ready pulse; a new if_req after reset is granted normally.
